// File: rtl/psk_pkg.sv
// psk_pkg: shared state encoding, counter width helper and constants for psk_serializer
package psk_pkg;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    localparam int UNDERRUN_CNT_W = 16;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/psk_bit_timer.sv
// psk_bit_timer: clock-per-bit and bit-per-symbol counter pair with bit_tick/symbol_end strobes
module psk_bit_timer import psk_pkg::*; #(
    parameter int CLKS_PER_BIT    = 4,
    parameter int BITS_PER_SYMBOL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic bit_tick,
    output logic symbol_end
);
    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int BW = cnt_width(BITS_PER_SYMBOL);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_SYMBOL - 1);

    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_tick   = enable && clk_cnt_q == CLK_LAST;
        symbol_end = bit_tick && bit_cnt_q == BIT_LAST;
        clk_cnt_d  = restart ? '0 : !enable ? clk_cnt_q : bit_tick ? '0 : clk_cnt_q + CW'(1);
        bit_cnt_d  = (restart || symbol_end) ? '0 : bit_tick ? bit_cnt_q + BW'(1) : bit_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/psk_serializer.sv
// psk_serializer: FWFT-FIFO to serial PSK bit stream with optional DPSK encoding.
// Define PSK_UNDERRUN_CNT_EN to add the saturating underrun counter and its clear input.
module psk_serializer import psk_pkg::*; #(
    parameter int   SAMPLE_WIDTH    = 8,
    parameter int   BITS_PER_SYMBOL = 4,
    parameter int   CLKS_PER_BIT    = 4,
    parameter logic MSB_FIRST       = 1'b0,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    diff_en,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    empty,
    output logic                    read,
    output logic                    pwm,
    output logic                    symb_clk,
    output logic                    busy,
    output logic                    underrun
`ifdef PSK_UNDERRUN_CNT_EN
    ,
    input  logic                      underrun_clr,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);
    state_e                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] sr_q, sr_d;
    logic                    pwm_q, pwm_d, symb_q, symb_d, diff_q, diff_d, ref_q, ref_d;
    logic                    run_en, bit_tick, symbol_end, load, shift, data_bit, tx_bit;

    assign run_en = enable && state_q == ST_RUN;

    psk_bit_timer #(
        .CLKS_PER_BIT   (CLKS_PER_BIT),
        .BITS_PER_SYMBOL(BITS_PER_SYMBOL)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .enable    (run_en),
        .restart   (load),
        .bit_tick  (bit_tick),
        .symbol_end(symbol_end)
    );

    // The bit to send always sits at the send end of the post-update shift register.
    always_comb begin
        load     = !rst && enable && !empty && (state_q == ST_IDLE || symbol_end);
        underrun = !rst && symbol_end && empty;
        shift    = bit_tick && !symbol_end;
        read     = load;
        sr_d     = load ? sample : shift ? (MSB_FIRST ? sr_q << 1 : sr_q >> 1) : sr_q;
        data_bit = MSB_FIRST ? sr_d[SAMPLE_WIDTH-1] : sr_d[0];
        diff_d   = load ? diff_en : diff_q;
        tx_bit   = data_bit ^ (diff_d & ref_q);
        ref_d    = (load || shift) ? tx_bit : ref_q;
        pwm_d    = (load || shift) ? tx_bit : underrun ? IDLE_LEVEL : pwm_q;
        symb_d   = load ? !symb_q : symb_q;
        state_d  = load ? ST_RUN : underrun ? ST_IDLE : state_q;
        busy     = state_q == ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            pwm_q   <= IDLE_LEVEL;
            symb_q  <= 1'b0;
            diff_q  <= 1'b0;
            ref_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            pwm_q   <= pwm_d;
            symb_q  <= symb_d;
            diff_q  <= diff_d;
            ref_q   <= ref_d;
        end
    end

    assign pwm      = pwm_q;
    assign symb_clk = symb_q;

`ifdef PSK_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = underrun_clr ? '0 : (underrun && ucnt_q != '1) ? ucnt_q + UNDERRUN_CNT_W'(1) : ucnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ucnt_q <= '0;
        else     ucnt_q <= ucnt_d;
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_psk_serializer.sv
// tb_psk_serializer: scoreboard bench for psk_serializer; dut0 uses defaults, dut1 MSB_FIRST=1 and IDLE_LEVEL=1.
// Also exercises the PSK_UNDERRUN_CNT_EN counter when that macro is defined.
module tb_psk_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;

    logic       rst0, enable0, diff0, empty0, read0, pwm0, sc0, busy0, ur0;
    logic [7:0] sample0;
    logic       rst1, enable1, diff1, empty1, read1, pwm1, sc1, busy1, ur1;
    logic [7:0] sample1;
`ifdef PSK_UNDERRUN_CNT_EN
    logic        clr0, clr1;
    logic [15:0] cnt0, cnt1;
`endif

    psk_serializer dut0 (
        .clk(clk), .rst(rst0), .enable(enable0), .diff_en(diff0), .sample(sample0), .empty(empty0),
        .read(read0), .pwm(pwm0), .symb_clk(sc0), .busy(busy0), .underrun(ur0)
`ifdef PSK_UNDERRUN_CNT_EN
        , .underrun_clr(clr0), .underrun_cnt(cnt0)
`endif
    );

    psk_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .enable(enable1), .diff_en(diff1), .sample(sample1), .empty(empty1),
        .read(read1), .pwm(pwm1), .symb_clk(sc1), .busy(busy1), .underrun(ur1)
`ifdef PSK_UNDERRUN_CNT_EN
        , .underrun_clr(clr1), .underrun_cnt(cnt1)
`endif
    );

    logic [7:0] f0[$], f1[$];
    logic       exp0[$], exp1[$];
    int         rd0_n = 0, rd0_cyc = 0, ur0_n = 0, ur0_cyc = 0;
    int         rd1_n = 0, rd1_cyc = 0, ur1_n = 0, ur1_cyc = 0, sc1_n = 0;
    logic       sc1_prev = 1'b0, r0, r1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        empty0  = f0.size() == 0;
        sample0 = empty0 ? 8'h00 : f0[0];
        empty1  = f1.size() == 0;
        sample1 = empty1 ? 8'h00 : f1[0];
    endtask

    // Bits given in send order (b[3] first), each held for four clocks.
    task automatic exp_push(input int which, input logic [3:0] b);
        for (int i = 3; i >= 0; i--)
            for (int k = 0; k < 4; k++)
                if (which == 0) exp0.push_back(b[i]);
                else            exp1.push_back(b[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait0();
        int i;
        for (i = 0; i < 400; i++) begin
            tick();
            if (!busy0 && f0.size() == 0) break;
        end
        if (i == 400) begin
            checks++; errors++;
            $display("FAIL dut0 idle timeout: busy=%0b fifo=%0d", busy0, f0.size());
        end
    endtask

    task automatic wait1();
        int i;
        for (i = 0; i < 400; i++) begin
            tick();
            if (!busy1 && f1.size() == 0) break;
        end
        if (i == 400) begin
            checks++; errors++;
            $display("FAIL dut1 idle timeout: busy=%0b fifo=%0d", busy1, f1.size());
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: pop after the edge on which read was high.
    always @(posedge clk) begin
        r0 = read0;
        r1 = read1;
        #1;
        if (r0 && f0.size() > 0) void'(f0.pop_front());
        if (r1 && f1.size() > 0) void'(f1.pop_front());
        refresh();
    end

    always @(negedge clk) begin
        if (busy0) begin
            if (exp0.size() == 0) begin
                checks++; errors++;
                $display("FAIL pwm0 busy with no expectation: got %0b", pwm0);
            end else chk("pwm0 bit", pwm0, exp0.pop_front());
        end
        if (busy1) begin
            if (exp1.size() == 0) begin
                checks++; errors++;
                $display("FAIL pwm1 busy with no expectation: got %0b", pwm1);
            end else chk("pwm1 bit", pwm1, exp1.pop_front());
        end
        if (read0) begin rd0_n++; rd0_cyc = cyc; end
        if (ur0)   begin ur0_n++; ur0_cyc = cyc; end
        if (read1) begin rd1_n++; rd1_cyc = cyc; end
        if (ur1)   begin ur1_n++; ur1_cyc = cyc; end
        if (sc1 !== sc1_prev) sc1_n++;
        sc1_prev = sc1;
        if (!enable0) chk("read0 while disabled", read0, 0);
    end

    initial begin
        int base, c0;
        rst0 = 1; enable0 = 1; diff0 = 0;
        rst1 = 1; enable1 = 1; diff1 = 0;
`ifdef PSK_UNDERRUN_CNT_EN
        clr0 = 0; clr1 = 0;
`endif
        refresh();
        repeat (3) tick();
        chk("reset pwm0", pwm0, 0);
        chk("reset busy0", busy0, 0);
        chk("reset symb_clk0", sc0, 0);
        chk("reset read0", read0, 0);
        chk("reset underrun0", ur0, 0);
        chk("reset pwm1 idle high", pwm1, 1);
`ifdef PSK_UNDERRUN_CNT_EN
        chk("reset underrun_cnt0", cnt0, 0);
`endif
        rst0 = 0; rst1 = 0;
        tick();

        // A5 LSB first: 1,0,1,0 then underrun 16 cycles after read
        base = rd0_n;
        exp_push(0, 4'b1010);
        f0.push_back(8'hA5); refresh();
        wait0();
        chk("A5 reads", rd0_n - base, 1);
        chk("A5 underrun latency", ur0_cyc - rd0_cyc, 16);
        chk("A5 idle pwm", pwm0, 0);
        chk("A5 leftover", exp0.size(), 0);

        // DPSK: 0F -> 1,0,1,0 ; 00 -> 0,0,0,0
        diff0 = 1; base = rd0_n;
        exp_push(0, 4'b1010);
        exp_push(0, 4'b0000);
        f0.push_back(8'h0F); f0.push_back(8'h00); refresh();
        wait0();
        diff0 = 0;
        chk("diff reads", rd0_n - base, 2);
        chk("diff underrun latency", ur0_cyc - rd0_cyc, 16);
        chk("diff leftover", exp0.size(), 0);

        // enable low while idle with data waiting, then a 5-cycle freeze mid-bit
        enable0 = 0; base = rd0_n;
        f0.push_back(8'h06); refresh();
        repeat (3) tick();
        chk("disabled idle reads", rd0_n - base, 0);
        chk("disabled idle busy", busy0, 0);
        for (int k = 0; k < 4; k++) exp0.push_back(1'b0);
        for (int k = 0; k < 9; k++) exp0.push_back(1'b1);
        for (int k = 0; k < 4; k++) exp0.push_back(1'b1);
        for (int k = 0; k < 4; k++) exp0.push_back(1'b0);
        enable0 = 1;
        repeat (6) tick();
        enable0 = 0;
        repeat (5) tick();
        enable0 = 1;
        wait0();
        chk("freeze reads", rd0_n - base, 1);
        chk("freeze underrun latency", ur0_cyc - rd0_cyc, 21);
        chk("freeze leftover", exp0.size(), 0);

`ifdef PSK_UNDERRUN_CNT_EN
        chk("underrun_cnt after 3", cnt0, 3);
        exp_push(0, 4'b1000);
        f0.push_back(8'h01); refresh();
        repeat (16) tick();
        clr0 = 1;
        tick();
        clr0 = 0;
        chk("clr beats increment", cnt0, 0);
        wait0();
        chk("4th underrun latency", ur0_cyc - rd0_cyc, 16);
`endif

        // MSB first back-to-back C3, 3C
        base = rd1_n; c0 = cyc;
        exp_push(1, 4'b1100);
        exp_push(1, 4'b0011);
        f1.push_back(8'hC3); f1.push_back(8'h3C); refresh();
        wait1();
        chk("b2b reads", rd1_n - base, 2);
        chk("b2b symb toggles", sc1_n, 2);
        chk("b2b second read cycle", rd1_cyc - c0, 16);
        chk("b2b underrun cycle", ur1_cyc - c0, 32);
        chk("b2b idle pwm", pwm1, 1);

        // reset mid-symbol with IDLE_LEVEL=1
        base = rd1_n;
        for (int k = 0; k < 6; k++) exp1.push_back(1'b0);
        f1.push_back(8'h0F); f1.push_back(8'h0F); refresh();
        repeat (6) tick();
        rst1 = 1;
        tick();
        chk("rst pwm1", pwm1, 1);
        chk("rst busy1", busy1, 0);
        chk("rst symb_clk1", sc1, 0);
        chk("rst read1", read1, 0);
        repeat (2) tick();
        chk("rst held read1", read1, 0);
        chk("rst reads", rd1_n - base, 1);
        chk("rst leftover", exp1.size(), 0);
        exp_push(1, 4'b0000);
        rst1 = 0;
        wait1();
        chk("post rst reads", rd1_n - base, 2);
        chk("post rst idle pwm", pwm1, 1);
        chk("post rst leftover", exp1.size(), 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psk_serializer.md
Name: psk_serializer

Overview:
- Parametrised successor of the single-rate PSK bit serializer in modules/modulator_psk.
- Pops samples from a first-word-fall-through FIFO and shifts out BITS_PER_SYMBOL bits of each sample on pwm, holding each bit for CLKS_PER_BIT clocks.
- Adds configurable sample width, bit order, idle line level, optional runtime differential encoding (DPSK), a busy indicator and an underrun pulse.
- Sits between the sample FIFO and the RF/pwm output stage.

Parameters:
- SAMPLE_WIDTH, 8: FIFO word width.
- BITS_PER_SYMBOL, 4: bits transmitted per sample; legal range 1..SAMPLE_WIDTH; the remaining bits are discarded.
- CLKS_PER_BIT, 4: clocks each bit is held; must be >= 1.
- MSB_FIRST, 0: 0 sends bit 0 first and discards the upper bits; 1 sends bit SAMPLE_WIDTH-1 first and discards the lower bits.
- IDLE_LEVEL, 0: pwm level while not transmitting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, all state is frozen and read is 0.
- diff_en  in  1  differential encoding select; sampled only at each sample load.
- sample  in  SAMPLE_WIDTH  FIFO head data; valid whenever empty=0.
- empty  in  1  FIFO empty flag.
- read  out  1  one-cycle FIFO pop strobe.
- pwm  out  1  serial bit stream (registered).
- symb_clk  out  1  toggles on every sample load.
- busy  out  1  high while in ST_RUN.
- underrun  out  1  one-cycle pulse when a symbol ends and the FIFO is empty.

Behaviour:
- Reset (rst=1 at posedge, overrides enable): state=ST_IDLE, read=0, pwm=IDLE_LEVEL, symb_clk=0, busy=0, underrun=0, clk/bit counters=0, shift register=0, diff reference bit=0.
- read and underrun default to 0 every cycle; each is a single-cycle pulse.
- enable=0: state, counters, shift register, pwm and symb_clk hold; read=0; underrun=0.
- ST_IDLE, empty=0 and enable=1:
  - assert read; capture sample into the shift register; load counters to 0; toggle symb_clk; go to ST_RUN.
  - pwm takes the first bit on the same edge, so the bit appears the cycle after read.
- ST_IDLE, empty=1: remain in ST_IDLE, pwm=IDLE_LEVEL.
- ST_RUN:
  - clk counter increments each enabled cycle.
  - At CLKS_PER_BIT-1 the clk counter wraps to 0, the bit counter increments, the shift register shifts one position toward the send end, and pwm loads the next bit.
- End of symbol (bit counter = BITS_PER_SYMBOL-1 and clk counter = CLKS_PER_BIT-1):
  - empty=0: read, load the new sample, reset counters, toggle symb_clk, pwm loads the new first bit. Back-to-back symbols have no gap.
  - empty=1: go to ST_IDLE, pwm=IDLE_LEVEL, busy=0, underrun=1 for one cycle.
- Differential encoding:
  - diff_en is latched at sample load and applies to the whole symbol.
  - When active, the transmitted bit = data bit XOR diff reference; the reference then updates to the transmitted bit.
  - When inactive, the transmitted bit = data bit and the reference is updated to it as well.
  - The reference survives underrun and idle; only rst clears it.
- Degenerate parameters:
  - CLKS_PER_BIT=1: a new bit every cycle.
  - BITS_PER_SYMBOL=1: every symbol end is a single-bit end.
  - Counter widths use max(1, clog2(N)) so N=1 still gets a 1-bit counter.
- Per sample, the FIFO data is read exactly once, and only in the cycle read=1.

Optional Feature:
- Macro: PSK_UNDERRUN_CNT_EN.
- Defined:
  - adds output underrun_cnt (16 bits), cleared by rst, incremented on each underrun pulse, saturating at 16'hFFFF.
  - adds input underrun_clr (1 bit); synchronous clear that takes priority over an increment in the same cycle.
- Undefined: neither port nor the counter exists; behaviour is otherwise identical.

Decomposition:
- Package psk_pkg holds:
  - state encoding (ST_IDLE=0, ST_RUN=1);
  - a width helper function returning max(1, clog2(n));
  - the underrun counter width constant (16).
- One natural sub-module, psk_bit_timer: parametrised CLKS_PER_BIT/BITS_PER_SYMBOL counter pair with inputs enable and restart, and outputs bit_tick and symbol_end.

Test Plan:
- Defaults, FIFO holding 8'hA5 then empty: read at cycle 0; pwm = 1,0,1,0 (LSB-first nibble 5) for 4 clocks each from cycle 1; underrun pulse at cycle 16; pwm then returns to 0.
- MSB_FIRST=1, samples 8'hC3 and 8'h3C back-to-back: pwm = 1,1,0,0,0,0,1,1 with no idle gap; symb_clk toggles twice; exactly 2 read pulses.
- diff_en=1, samples 8'h0F then 8'h00: transmitted bits = 1,0,1,0 then 0,0,0,0.
- enable dropped for 5 cycles mid-bit: pwm and counters hold; total symbol length is 16+5 cycles; read stays 0 while enable is low.
- rst asserted mid-symbol with IDLE_LEVEL=1: on the next edge pwm=1, busy=0, symb_clk=0, and no read until rst is released and empty=0.
- PSK_UNDERRUN_CNT_EN defined, 3 isolated single samples: underrun_cnt=3; underrun_clr asserted in the same cycle as a 4th underrun gives underrun_cnt=0.
